fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side consumer for the 64-bit FIFO memory. It pops one word at a time from the FIFO's combinational head port and emits each word as two 32-bit beats on a valid/ready stream toward the 32-bit core-side bus. It sits between the FIFO status/data outputs and the pipeline's memory-mapped load path. It never pops more than it can hold.

## Interface
- BEAT_W, 32, beat width; FIFO word width is 2*BEAT_W
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  permits new pops; a word already in flight always completes
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  2*BEAT_W  FIFO head word, combinational, valid while fifo_empty=0
- fifo_rd  out  1  pop strobe to FIFO, one cycle per word
- out_valid  out  1  beat valid
- out_data  out  BEAT_W  beat payload
- out_last  out  1  high on the second beat of a word
- out_ready  in  1  downstream accepts the beat when out_valid & out_ready
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, BEAT0, BEAT1. A 64-bit hold register holds the popped word.
- IDLE: fifo_rd = enable & ~fifo_empty (combinational). When it is high, fifo_data is captured into hold at the clock edge and the state goes to BEAT0.
- BEAT0: out_valid=1, out_data=first half, out_last=0. On out_ready the state goes to BEAT1.
- BEAT1: out_valid=1, out_data=second half, out_last=1.
  - On out_ready with enable & ~fifo_empty: fifo_rd=1 in the same cycle, the next word is captured, and the state goes to BEAT0 (back-to-back).
  - On out_ready otherwise: the state goes to IDLE.
- fifo_rd is never asserted while fifo_empty=1 or outside IDLE/accepted-BEAT1.
- out_data and out_last hold stable while out_valid & ~out_ready. No beat is dropped or duplicated.
- Deasserting enable mid-word does not abort the word; both beats are still emitted.
- rst mid-word: state→IDLE, the hold word is discarded. The popped word is lost by design; software resets the FIFO together with this block.

## Timing
- Reset values: fifo_rd=0, out_valid=0, out_data=0, out_last=0, busy=0, hold=0, state=IDLE.
- Pop-to-first-beat latency: 1 cycle (fifo_rd at edge N, out_valid from N+1).
- Throughput: one 64-bit word per 2 cycles with out_ready held high and the FIFO non-empty.
- If fifo_empty falls while in IDLE with enable=1, fifo_rd rises in that same cycle.
- All outputs except fifo_rd are registered or decoded from state/hold only. fifo_rd is combinational from state, enable, fifo_empty, and out_ready.

## Configuration
- FIFO_DRAIN_HI_FIRST_EN defined: BEAT0 carries hold[2*BEAT_W-1:BEAT_W] and BEAT1 carries hold[BEAT_W-1:0].
- Not defined (default): BEAT0 carries the low half and BEAT1 the high half.
- Handshake, timing, and out_last are identical in both builds.

## Structure
- Shared package fifo_drain_pkg: the state typedef (IDLE/BEAT0/BEAT1, 2-bit encoding 00/01/10) and the BEAT_W default constant.
- Single module, no sub-module. FSM, hold register, and beat mux are small enough to stay flat.

## Test plan
- Reset, then push 64'h1122334455667788 with enable=1 and out_ready=1 → fifo_rd high for one cycle; beats 32'h55667788 (last=0) then 32'h11223344 (last=1); busy low after.
- Same push with FIFO_DRAIN_HI_FIRST_EN defined → 32'h11223344 then 32'h55667788.
- Push 4 words, out_ready=1 throughout → 8 consecutive valid beats with no bubbles, fifo_rd pulsing every 2nd cycle, and the FIFO empty at the end.
- Hold out_ready=0 for 5 cycles during BEAT0 → out_data/out_last stable, no additional fifo_rd, then normal completion.
- FIFO empty with enable=1 for 10 cycles → fifo_rd never asserted, out_valid=0; enable=0 with a non-empty FIFO → no pop.
- Assert rst during BEAT1 → next cycle all outputs at reset values, state IDLE; the next word in the FIFO is popped normally after rst deasserts.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// ============================================================================
// Module   : fifo_drain_pkg
// Purpose  : Shared state encoding and width default for fifo_drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_drain_pkg;

  localparam int BEAT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_drain.sv
// ============================================================================
// Module   : fifo_drain
// Purpose  : Pops 64-bit FIFO words and emits each as two 32-bit stream beats.
//            Define FIFO_DRAIN_HI_FIRST_EN to send the upper half first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [2*BEAT_W-1:0] fifo_data,
  output logic                fifo_rd,
  output logic                out_valid,
  output logic [BEAT_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [2*BEAT_W-1:0] hold_q, hold_d;
  logic                w_can_pop;
  logic [BEAT_W-1:0]   w_first_half;
  logic [BEAT_W-1:0]   w_second_half;

  assign w_can_pop = enable & ~fifo_empty;

`ifdef FIFO_DRAIN_HI_FIRST_EN
  assign w_first_half  = hold_q[2*BEAT_W-1:BEAT_W];
  assign w_second_half = hold_q[BEAT_W-1:0];
`else
  assign w_first_half  = hold_q[BEAT_W-1:0];
  assign w_second_half = hold_q[2*BEAT_W-1:BEAT_W];
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_can_pop) begin
          fifo_rd = 1'b1;
          hold_d  = fifo_data;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (out_ready) state_d = BEAT1;
      end
      BEAT1: begin
        if (out_ready) begin
          if (w_can_pop) begin
            fifo_rd = 1'b1;
            hold_d  = fifo_data;
            state_d = BEAT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop during reset would lose a word that the FIFO still considers read.
    if (rst) fifo_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign out_last  = (state_q == BEAT1);

  always_comb begin
    out_data = '0;
    case (state_q)
      BEAT0:   out_data = w_first_half;
      BEAT1:   out_data = w_second_half;
      default: out_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain.sv
// ============================================================================
// Module   : tb_fifo_drain
// Purpose  : Self-checking bench for fifo_drain against a FIFO/beat-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_data = '0;
  logic        fifo_rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q[$];
  logic [32:0] exp_beats[$];

  logic        s_rd, s_valid, s_last, s_busy;
  logic [31:0] s_data;
  logic        m_rd, m_valid, m_hs, m_last;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  fifo_drain #(.BEAT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 64'h0;
  endtask

  // Advance one clock; sample DUT at negedge and derive model expectations
  // from the rule "at most one word (two beats) outstanding".
  task automatic cycle();
    int n;
    logic [63:0] w;
    @(negedge clk);
    s_rd = fifo_rd; s_valid = out_valid; s_data = out_data;
    s_last = out_last; s_busy = busy;
    n = exp_beats.size();
    m_valid = (n > 0);
    m_rd = !rst && enable && (q.size() > 0) && (n == 0 || (n == 1 && out_ready));
    m_hs = m_valid && out_ready;
    m_data = m_valid ? exp_beats[0][31:0] : 32'h0;
    m_last = m_valid ? exp_beats[0][32] : 1'b0;
    @(posedge clk);
    #1;
    if (rst) exp_beats.delete();
    else if (m_hs) void'(exp_beats.pop_front());
    if (s_rd && q.size() > 0) begin
      w = q.pop_front();
      if (!rst) begin
`ifdef FIFO_DRAIN_HI_FIRST_EN
        exp_beats.push_back({1'b0, w[63:32]});
        exp_beats.push_back({1'b1, w[31:0]});
`else
        exp_beats.push_back({1'b0, w[31:0]});
        exp_beats.push_back({1'b1, w[63:32]});
`endif
      end
    end
    drive_fifo();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
    q.push_back(64'hDEADBEEFCAFEF00D); drive_fifo();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b exp=0", s_rd); end
      n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
      n_tests++; if (s_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", s_data); end
      n_tests++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", s_last); end
      n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    end
    q.delete(); drive_fifo();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] b0, b1;
`ifdef FIFO_DRAIN_HI_FIRST_EN
    b0 = 32'h11223344; b1 = 32'h55667788;
`else
    b0 = 32'h55667788; b1 = 32'h11223344;
`endif
    enable = 1'b1; out_ready = 1'b1;
    q.push_back(64'h1122334455667788); drive_fifo();
    cycle();
    n_tests++; if (s_rd !== 1'b1 || s_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop rd=%b valid=%b exp rd=1 valid=0", s_rd, s_valid); end
    cycle();
    n_tests++; if ({s_valid, s_last, s_data, s_rd} !== {1'b1, 1'b0, b0, 1'b0}) begin n_fail++; $display("FAIL single_beat0 valid=%b last=%b data=%h rd=%b exp 1 0 %h 0", s_valid, s_last, s_data, s_rd, b0); end
    cycle();
    n_tests++; if ({s_valid, s_last, s_data, s_rd} !== {1'b1, 1'b1, b1, 1'b0}) begin n_fail++; $display("FAIL single_beat1 valid=%b last=%b data=%h rd=%b exp 1 1 %h 0", s_valid, s_last, s_data, s_rd, b1); end
    cycle();
    n_tests++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle busy=%b valid=%b exp 0 0", s_busy, s_valid); end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back({$urandom, $urandom});
    drive_fifo();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++; if (s_rd !== (i < 8 && i % 2 == 0)) begin n_fail++; $display("FAIL b2b_rd cyc=%0d got=%b exp=%b", i, s_rd, (i < 8 && i % 2 == 0)); end
      n_tests++; if (s_valid !== (i >= 1 && i <= 8)) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, s_valid, (i >= 1 && i <= 8)); end
      if (m_hs) begin
        n_tests++; if ({s_last, s_data} !== {m_last, m_data}) begin n_fail++; $display("FAIL b2b_beat cyc=%0d got=%b/%h exp=%b/%h", i, s_last, s_data, m_last, m_data); end
      end
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_fifo_empty got=%0d words exp=0", q.size()); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    enable = 1'b1; out_ready = 1'b0;
    q.push_back({$urandom, $urandom}); q.push_back({$urandom, $urandom}); drive_fifo();
    held = '0;
    for (int i = 0; i < 12; i++) begin
      out_ready = (i >= 6);
      cycle();
      n_tests++; if (s_rd !== m_rd) begin n_fail++; $display("FAIL stall_rd cyc=%0d got=%b exp=%b", i, s_rd, m_rd); end
      n_tests++; if (s_valid !== m_valid) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", i, s_valid, m_valid); end
      if (i == 1) held = s_data;
      if (i >= 1 && i <= 5) begin
        n_tests++; if (s_data !== held || s_last !== 1'b0) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/0", i, s_data, s_last, held); end
      end
      if (m_hs) begin
        n_tests++; if ({s_last, s_data} !== {m_last, m_data}) begin n_fail++; $display("FAIL stall_beat cyc=%0d got=%b/%h exp=%b/%h", i, s_last, s_data, m_last, m_data); end
      end
    end
  endtask

  task automatic test_empty_disable();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++; if (s_rd !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL empty_idle cyc=%0d rd=%b valid=%b exp 0 0", i, s_rd, s_valid); end
    end
    enable = 1'b0;
    q.push_back({$urandom, $urandom}); drive_fifo();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++; if (s_rd !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL disabled_idle cyc=%0d rd=%b valid=%b exp 0 0", i, s_rd, s_valid); end
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_tests++; if (s_rd !== m_rd || s_valid !== m_valid) begin n_fail++; $display("FAIL enable_drain cyc=%0d rd=%b valid=%b exp %b %b", i, s_rd, s_valid, m_rd, m_valid); end
      if (m_hs) begin
        n_tests++; if ({s_last, s_data} !== {m_last, m_data}) begin n_fail++; $display("FAIL enable_beat cyc=%0d got=%b/%h exp=%b/%h", i, s_last, s_data, m_last, m_data); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit in_beat1;
    enable = 1'b1; out_ready = 1'b1;
    q.push_back({$urandom, $urandom}); q.push_back({$urandom, $urandom}); drive_fifo();
    in_beat1 = 1'b0;
    for (int i = 0; i < 6 && !in_beat1; i++) begin
      cycle();
      if (s_valid && !s_last) in_beat1 = 1'b1;
    end
    n_tests++; if (!in_beat1) begin n_fail++; $display("FAIL rstmid_reach_beat1 got=0 exp=1"); end
    rst = 1'b1;
    cycle();
    n_tests++; if (s_last !== 1'b1 || s_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_during last=%b rd=%b exp 1 0", s_last, s_rd); end
    rst = 1'b0;
    cycle();
    n_tests++; if ({s_valid, s_data, s_last, s_busy} !== 35'h0) begin n_fail++; $display("FAIL rstmid_after valid=%b data=%h last=%b busy=%b exp all 0", s_valid, s_data, s_last, s_busy); end
    n_tests++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL rstmid_repop got=%b exp=1", s_rd); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_tests++; if (s_rd !== m_rd || s_valid !== m_valid) begin n_fail++; $display("FAIL rstmid_resume cyc=%0d rd=%b valid=%b exp %b %b", i, s_rd, s_valid, m_rd, m_valid); end
      if (m_hs) begin
        n_tests++; if ({s_last, s_data} !== {m_last, m_data}) begin n_fail++; $display("FAIL rstmid_beat cyc=%0d got=%b/%h exp=%b/%h", i, s_last, s_data, m_last, m_data); end
      end
    end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [32:0] prev_beat;
    prev_stall = 1'b0; prev_beat = '0;
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0 && q.size() < 6) q.push_back({$urandom, $urandom});
      drive_fifo();
      cycle();
      n_tests++; if (s_rd !== m_rd) begin n_fail++; $display("FAIL rand_rd cyc=%0d got=%b exp=%b", i, s_rd, m_rd); end
      n_tests++; if (s_valid !== m_valid || s_busy !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d valid=%b busy=%b exp=%b", i, s_valid, s_busy, m_valid); end
      if (m_valid) begin
        n_tests++; if ({s_last, s_data} !== {m_last, m_data}) begin n_fail++; $display("FAIL rand_beat cyc=%0d got=%b/%h exp=%b/%h", i, s_last, s_data, m_last, m_data); end
      end
      if (prev_stall) begin
        n_tests++; if ({s_last, s_data} !== prev_beat) begin n_fail++; $display("FAIL rand_stable cyc=%0d got=%h exp=%h", i, {s_last, s_data}, prev_beat); end
      end
      prev_stall = s_valid && !out_ready;
      prev_beat  = {s_last, s_data};
    end
  endtask

  initial begin
    drive_fifo();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_empty_disable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
